// File: rtl/sram_fifo_ctrl_256x36.sv
// sram_fifo_ctrl_256x36
//
// Synchronous FIFO controller wrapping one 256x36 single-read/single-write SRAM
// macro. Entries are written straight into the SRAM and prefetched into a
// 2-entry output register queue. The queue hides the macro's one-cycle read
// latency, so one enqueue and one dequeue can complete every cycle.
// Capacity is 2^ADDR_W + 2 entries.
//
// Ports:
//   clock, reset              single clock; synchronous active-high reset
//   enq_valid/enq_ready/enq_bits   producer handshake and data
//   deq_valid/deq_ready/deq_bits   consumer handshake and head entry
//   count                     total occupancy (SRAM + output queue)
//   sram_W0_*                 macro write port (addr, en, data, clk)
//   sram_R0_*                 macro read request (addr, en, clk)
//   sram_R0_data              macro read data, valid the cycle after R0_en
module sram_fifo_ctrl_256x36 #(
    parameter int unsigned DATA_W = 36,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] sram_W0_addr,
    output logic              sram_W0_en,
    output logic [DATA_W-1:0] sram_W0_data,
    output logic              sram_W0_clk,
    output logic [ADDR_W-1:0] sram_R0_addr,
    output logic              sram_R0_en,
    output logic              sram_R0_clk,
    input  logic [DATA_W-1:0] sram_R0_data
);

    localparam int unsigned     CntW     = ADDR_W + 1;
    localparam logic [CntW-1:0] MemDepth = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
    // SRAM-resident entries, including one whose read is still in flight.
    logic [CntW-1:0]           mem_cnt_q, mem_cnt_d;
    logic                      inflight_q, inflight_d;
    logic [1:0][DATA_W-1:0]    oq_q, oq_d;
    logic [1:0]                oq_cnt_q, oq_cnt_d;

    logic                      enq_fire;
    logic                      deq_fire;
    logic                      fetch;
    logic                      capture;
    // Output-queue slots already claimed once this cycle's dequeue is taken out.
    logic [2:0]                oq_claimed;

    // enq_ready sees only registered state, never deq_ready.
    assign enq_ready = !reset && (mem_cnt_q != MemDepth);
    assign deq_valid = !reset && (oq_cnt_q != '0);
    assign deq_bits  = oq_q[0];
    assign count     = reset ? '0 : (mem_cnt_q + CntW'(oq_cnt_q));

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;
    assign capture  = inflight_q;

    assign oq_claimed = {1'b0, oq_cnt_q} + {2'b00, inflight_q} - {2'b00, deq_fire};

    // Only fetch entries not already being read, and only if the captured word
    // will have a free output slot when it lands.
    assign fetch = !reset && (mem_cnt_q != CntW'(inflight_q)) && (oq_claimed < 3'd2);

    assign sram_W0_clk  = clock;
    assign sram_W0_en   = enq_fire;
    assign sram_W0_addr = wr_ptr_q;
    assign sram_W0_data = enq_bits;

    assign sram_R0_clk  = clock;
    assign sram_R0_en   = fetch;
    assign sram_R0_addr = rd_ptr_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = fetch;
        // A slot is released only at capture, so a write can never land on a
        // slot whose read is still outstanding.
        mem_cnt_d  = mem_cnt_q + CntW'(enq_fire) - CntW'(capture);
        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Shift out the head first, then append the captured word at the new tail.
    always_comb begin
        oq_d     = oq_q;
        oq_cnt_d = oq_cnt_q;
        if (deq_fire) begin
            oq_d[0]  = oq_q[1];
            oq_cnt_d = oq_cnt_d - 2'd1;
        end
        if (capture) begin
            // Fetch gating keeps the post-shift count at 0 or 1 here.
            oq_d[oq_cnt_d[0]] = sram_R0_data;
            oq_cnt_d          = oq_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            oq_cnt_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            oq_cnt_q   <= oq_cnt_d;
        end
    end

    // Queue payload needs no reset; validity is carried by oq_cnt_q.
    always_ff @(posedge clock) begin
        oq_q <= oq_d;
    end

endmodule

// File: tb/tb_sram_fifo_ctrl_256x36.sv
module tb_sram_fifo_ctrl_256x36;

    localparam logic [35:0] Poison = 36'hF_DEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset;
    logic        enq_valid;
    logic        enq_ready;
    logic [35:0] enq_bits;
    logic        deq_valid;
    logic        deq_ready;
    logic [35:0] deq_bits;
    logic [8:0]  count;
    logic [7:0]  sram_W0_addr;
    logic        sram_W0_en;
    logic [35:0] sram_W0_data;
    logic        sram_W0_clk;
    logic [7:0]  sram_R0_addr;
    logic        sram_R0_en;
    logic        sram_R0_clk;
    logic [35:0] sram_R0_data;

    sram_fifo_ctrl_256x36 dut (
        .clock        (clock),
        .reset        (reset),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_bits     (enq_bits),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_bits     (deq_bits),
        .count        (count),
        .sram_W0_addr (sram_W0_addr),
        .sram_W0_en   (sram_W0_en),
        .sram_W0_data (sram_W0_data),
        .sram_W0_clk  (sram_W0_clk),
        .sram_R0_addr (sram_R0_addr),
        .sram_R0_en   (sram_R0_en),
        .sram_R0_clk  (sram_R0_clk),
        .sram_R0_data (sram_R0_data)
    );

    always #5 clock = ~clock;

    // SRAM macro model: registered read; poison returned when no read was issued.
    logic [35:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end
    always @(posedge sram_W0_clk) begin
        if (sram_W0_en) mem[sram_W0_addr] <= sram_W0_data;
    end
    always @(posedge sram_R0_clk) begin
        sram_R0_data <= sram_R0_en ? mem[sram_R0_addr] : Poison;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the FIFO is an ordered queue of words; each word also
    // remembers the cycle it was accepted for the latency bound.
    logic [35:0] mq[$];
    int          mt[$];
    int          cyc = 0;
    int          front_since = 0;
    logic [7:0]  wr_n = '0;
    logic [7:0]  rd_n = '0;
    logic [7:0]  last_rd = '0;
    int          wraps = 0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            chk("rst_enq_ready", enq_ready, 0);
            chk("rst_deq_valid", deq_valid, 0);
            chk("rst_count", count, 0);
            chk("rst_w0_en", sram_W0_en, 0);
            chk("rst_r0_en", sram_R0_en, 0);
            mq.delete();
            mt.delete();
            front_since = cyc;
            wr_n = '0;
            rd_n = '0;
        end else begin
            chk("count", count, mq.size());
            if (mq.size() < 256) chk("enq_ready_open", enq_ready, 1);
            if (mq.size() == 258) chk("enq_ready_full", enq_ready, 0);
            if (mq.size() == 0) begin
                chk("deq_valid_empty", deq_valid, 0);
            end else begin
                // Head must be presented within 3 cycles of enqueue and 2 of
                // becoming head.
                if (cyc - mt[0] >= 3 && cyc - front_since >= 2)
                    chk("deq_valid_due", deq_valid, 1);
                if (deq_valid) chk("deq_bits", deq_bits, mq[0]);
            end
            chk("w0_en", sram_W0_en, enq_valid & enq_ready);
            if (sram_W0_en) begin
                chk("w0_addr", sram_W0_addr, wr_n);
                chk("w0_data", sram_W0_data, enq_bits);
                wr_n++;
            end
            if (sram_R0_en) begin
                chk("r0_addr", sram_R0_addr, rd_n);
                rd_n++;
                if (last_rd == 8'hFF && sram_R0_addr == 8'h00) wraps++;
                last_rd = sram_R0_addr;
            end
            if (deq_valid && deq_ready && mq.size() > 0) begin
                void'(mq.pop_front());
                void'(mt.pop_front());
                front_since = cyc;
            end
            if (enq_valid && enq_ready) begin
                mq.push_back(enq_bits);
                mt.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_n(input int n, input logic [35:0] base, input string name);
        int got = 0;
        deq_ready = 1'b0;
        for (int c = 0; c < n + 200 && got < n; c++) begin
            enq_valid = 1'b1;
            enq_bits  = base + 36'(got);
            @(negedge clock);
            if (enq_ready) got++;
            step();
        end
        enq_valid = 1'b0;
        chk(name, got, n);
    endtask

    task automatic drain(input string name);
        int c = 0;
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        while (c < 800 && count != 0) begin
            step();
            c++;
        end
        @(negedge clock);
        chk(name, count, 0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_enq, n_deq, t0, first, last;

        // Reset held 3 cycles with enq_valid asserted.
        reset = 1'b1;
        enq_valid = 1'b1;
        enq_bits = 36'h5;
        deq_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("reset_enq_ready", enq_ready, 0);
            chk("reset_count", count, 0);
            step();
        end
        reset = 1'b0;
        enq_valid = 1'b0;
        @(negedge clock);
        chk("post_reset_enq_ready", enq_ready, 1);
        step();

        // Single entry latency.
        enq_valid = 1'b1;
        enq_bits = 36'h9_ABCD_1234;
        deq_ready = 1'b1;
        @(negedge clock);
        chk("single_w0_en", sram_W0_en, 1);
        chk("single_w0_addr", sram_W0_addr, 0);
        step();
        enq_valid = 1'b0;
        @(negedge clock);
        chk("single_fetch_en", sram_R0_en, 1);
        chk("single_fetch_addr", sram_R0_addr, 0);
        chk("single_t1_deq_valid", deq_valid, 0);
        step();
        @(negedge clock);
        chk("single_t2_deq_valid", deq_valid, 0);
        step();
        @(negedge clock);
        chk("single_t3_deq_valid", deq_valid, 1);
        chk("single_t3_deq_bits", deq_bits, 36'h9_ABCD_1234);
        step();
        @(negedge clock);
        chk("single_t4_count", count, 0);
        chk("single_t4_deq_valid", deq_valid, 0);
        step();

        // Fill to full, then drain in order.
        push_n(258, 36'h0, "fill_accepted");
        enq_valid = 1'b1;
        enq_bits = 36'h777;
        repeat (3) begin
            @(negedge clock);
            chk("full_enq_ready", enq_ready, 0);
            chk("full_count", count, 258);
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        n_deq = 0;
        for (int c = 0; c < 600 && n_deq < 258; c++) begin
            @(negedge clock);
            if (deq_valid) begin
                chk("drain_order", deq_bits, 36'(n_deq));
                n_deq++;
            end
            step();
        end
        chk("drain_total", n_deq, 258);
        @(negedge clock);
        chk("drain_count_zero", count, 0);
        step();

        // Full-throughput stream with pointer wrap.
        wraps = 0;
        deq_ready = 1'b1;
        n_enq = 0;
        n_deq = 0;
        t0 = -1;
        first = -1;
        last = -1;
        for (int c = 0; c < 1300 && n_deq < 1000; c++) begin
            enq_valid = (n_enq < 1000);
            enq_bits  = 36'(1000 + n_enq);
            @(negedge clock);
            if (enq_valid && enq_ready) begin
                if (n_enq == 0) t0 = c;
                n_enq++;
            end
            if (deq_valid) begin
                chk("stream_data", deq_bits, 36'(1000 + n_deq));
                if (n_deq == 0) first = c;
                last = c;
                n_deq++;
            end
            step();
        end
        enq_valid = 1'b0;
        chk("stream_deq_total", n_deq, 1000);
        chk("stream_first_latency", first - t0, 3);
        chk("stream_no_bubbles", last - first, 999);
        chk("stream_ptr_wraps", wraps >= 3, 1);
        drain("stream_drained");

        // Random backpressure.
        for (int i = 0; i < 10000; i++) begin
            enq_valid = 1'($urandom_range(0, 1));
            deq_ready = 1'($urandom_range(0, 1));
            enq_bits  = {1'b0, 3'(i), 32'($urandom)};
            step();
        end
        drain("random_drained");

        // Reset mid-operation with a read in flight.
        push_n(100, 36'h4_0000, "mid_fill_accepted");
        repeat (5) step();
        @(negedge clock);
        chk("mid_count_100", count, 100);
        step();
        deq_ready = 1'b1;
        @(negedge clock);
        chk("mid_fetch_on_deq", sram_R0_en, 1);
        step();
        deq_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_post_count", count, 0);
        chk("mid_post_deq_valid", deq_valid, 0);
        step();
        enq_valid = 1'b1;
        enq_bits = 36'h1;
        deq_ready = 1'b1;
        step();
        enq_valid = 1'b0;
        n_deq = 0;
        for (int c = 0; c < 10 && n_deq == 0; c++) begin
            @(negedge clock);
            if (deq_valid) begin
                chk("mid_after_reset_data", deq_bits, 36'h1);
                n_deq++;
            end
            step();
        end
        chk("mid_after_reset_seen", n_deq, 1);
        repeat (4) step();
        @(negedge clock);
        chk("mid_final_count", count, 0);
        chk("mid_final_deq_valid", deq_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl_256x36.md
# sram_fifo_ctrl_256x36

Synchronous FIFO controller wrapping one `sram_1R_1W_0RW_0M_256x36` macro. It presents ready/valid enqueue and dequeue ports to the datapath and drives the macro's write and read ports. A 2-entry output register queue hides the macro's one-cycle registered-read latency, so the FIFO sustains one enqueue and one dequeue per cycle. Total capacity is 258 entries: 256 in the SRAM and 2 in the output queue.

## Interface
- `DATA_W`, default 36: entry width; must match the macro.
- `ADDR_W`, default 8: SRAM address width; depth is 2^ADDR_W = 256.
- `clock` in 1: single clock for all logic; also drives `sram_W0_clk` and `sram_R0_clk`.
- `reset` in 1: synchronous, active-high.
- `enq_valid` in 1: producer has data.
- `enq_ready` out 1: FIFO accepts data.
- `enq_bits` in DATA_W: enqueue data.
- `deq_valid` out 1: `deq_bits` valid.
- `deq_ready` in 1: consumer takes data.
- `deq_bits` out DATA_W: head entry.
- `count` out 9: total occupancy, 0..258 (SRAM plus output queue).
- `sram_W0_addr` out 8, `sram_W0_en` out 1, `sram_W0_data` out 36, `sram_W0_clk` out 1: macro write port.
- `sram_R0_addr` out 8, `sram_R0_en` out 1, `sram_R0_clk` out 1: macro read request.
- `sram_R0_data` in 36: macro read data, valid the cycle after an `R0_en` request.

## Operation
- **State.**
  - `wr_ptr`, `rd_ptr`: 8 bits each, wrapping 255→0.
  - `mem_cnt`: 9 bits, 0..256. Counts SRAM-resident entries, including an entry whose read is in flight.
  - `inflight`: 1 bit.
  - `oq[0..1]` with `oq_cnt`: 0..2.
- **Enqueue fire.** `enq_fire = enq_valid & enq_ready`, where `enq_ready = !reset & (mem_cnt != 256)`.
  - On fire: `sram_W0_en=1`, `sram_W0_addr=wr_ptr`, `sram_W0_data=enq_bits`, and `wr_ptr` increments.
  - Otherwise `sram_W0_en=0`.
- **Fetch.**
  - Condition: `fetch = !reset & (mem_cnt - inflight != 0) & (oq_cnt + inflight - deq_fire < 2)`.
  - On fetch: `sram_R0_en=1`, `sram_R0_addr=rd_ptr`, `rd_ptr` increments, and `inflight` is set next cycle.
  - Otherwise `sram_R0_en=0`.
  - `sram_R0_addr` is don't-care when `R0_en=0` and is driven as `rd_ptr`.
- **Capture.** When `inflight=1`, `sram_R0_data` is written into the output queue tail and `mem_cnt` decrements.
  - The SRAM slot is freed only at capture, never at fetch. This guarantees a write can never overwrite a slot whose read is outstanding.
- **Dequeue fire.** `deq_fire = deq_valid & deq_ready`, where `deq_valid = (oq_cnt != 0)` and `deq_bits = oq[0]`.
  - On fire the queue shifts.
  - Capture and dequeue in the same cycle are legal: the queue shifts, then appends.
- **`mem_cnt` update.** Next value is `mem_cnt + enq_fire - capture`. Simultaneous enqueue and capture leaves it unchanged.
- **`count` output.** `count = mem_cnt + oq_cnt`.
- **Data integrity.** `sram_R0_data` is X when no read was issued. It must never be captured unless `inflight=1`. `deq_bits` is undefined while `deq_valid=0`.
- **Ordering.** Strict FIFO order. No bypass path around the SRAM.
- **Reset.**
  - Pointers, `mem_cnt`, `inflight` and `oq_cnt` go to 0.
  - All outputs are 0 during reset: `enq_ready`, `deq_valid`, `sram_W0_en`, `sram_R0_en`, `count`.
  - Reset mid-stream discards all contents, including any in-flight read.
  - The first cycle after reset deasserts has `enq_ready=1`.

## Timing
- The SRAM write commits at the clock edge ending the enqueue cycle T.
- Minimum enqueue-to-dequeue latency on an empty FIFO:
  - Enqueue accepted in T, fetch in T+1, capture in T+2.
  - `deq_valid=1` in T+3.
- Steady state with `enq_valid=deq_ready=1` continuously: one entry per cycle in each direction, no bubbles.
- A fetch may issue in the same cycle as a dequeue that frees an output slot. This is the `- deq_fire` term.
- `enq_ready` depends only on registered state, with no combinational path from `deq_ready`.
- `deq_valid` and `deq_bits` come from registers.
- Full condition: `mem_cnt=256` gives `enq_ready=0`. A capture in that cycle raises `enq_ready` next cycle, not the same cycle.

## Test plan
- **Reset.** Assert `reset` for 3 cycles with `enq_valid=1`. Required: `enq_ready=0`, `sram_W0_en=0`, `deq_valid=0`, `count=0`. In the first cycle after reset, `enq_ready=1`.
- **Single entry latency.** Enqueue 36'h9_ABCD_1234 at cycle T into an empty FIFO with `deq_ready=1`. Required: fetch of addr 0 at T+1, `deq_valid` first high at T+3 with that value, `count` returning to 0 at T+4.
- **Fill to full.** Push 0..257 with `deq_ready=0`. Required: 258 accepted, `count=258`, `enq_ready=0` afterwards. Then drain with `deq_ready=1`: data 0..257 in order, `count` reaching 0.
- **Full throughput and wrap.** Stream 1000 incrementing words with `enq_valid=deq_ready=1`. Required: after the 3-cycle fill, one dequeue per cycle; pointers wrap 255→0 at least 3 times; no loss or reordering.
- **Random backpressure.** Apply 50% random `enq_valid` and `deq_ready` for 10k cycles. Required: matches a scoreboard, `count` always equals the model occupancy, `sram_R0_data` is never captured without a preceding `R0_en`.
- **Reset mid-operation.** Fill to 100 entries with a read in flight, then assert `reset` for 1 cycle. Required: `count=0` and `deq_valid=0` the next cycle; a subsequent enqueue of 36'h1 dequeues 36'h1, with no stale data.
